// File: rtl/vga_sched_pkg.sv
// Shared types and defaults for the VGA display scheduler: state encoding,
// field widths and the pending-update record.
package vga_sched_pkg;

  localparam int STATUS_W = 7;
  localparam int NUM_W    = 4;

  localparam bit                  DEF_VS_POL        = 1'b0;
  localparam int                  DEF_SPLASH_FRAMES = 60;
  localparam int                  DEF_BLINK_FRAMES  = 15;
  localparam int                  DEF_FLASH_TOGGLES = 6;
  localparam logic [STATUS_W-1:0] DEF_SPLASH_STATUS = 7'h00;

  typedef enum logic [1:0] {
    ST_SPLASH = 2'd0,
    ST_RUN    = 2'd1,
    ST_FLASH  = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [STATUS_W-1:0] status;
    logic [NUM_W-1:0]    num;
    logic                flash;
  } pend_t;

endpackage

// File: rtl/vga_frame_edge.sv
// Frame boundary detector: registers vsync and flags the inactive->active
// transition. tick is combinational for same-edge use, frame_tick is its registered copy.
module vga_frame_edge #(
  parameter bit VS_POL = vga_sched_pkg::DEF_VS_POL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic tick,
  output logic frame_tick
);

  logic vs_d;

  assign tick = (vsync == VS_POL) && (vs_d != VS_POL);

  // vs_d starts at the active level so a vsync already active at release is not a boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d       <= VS_POL;
      frame_tick <= 1'b0;
    end else begin
      vs_d       <= vsync;
      frame_tick <= tick;
    end
  end

endmodule

// File: rtl/vga_disp_sched.sv
// Frame-synchronous update scheduler for vga_pic: holds one pending update,
// commits it at a frame boundary, and sequences splash and blink via blank.
module vga_disp_sched import vga_sched_pkg::*; #(
  parameter bit                  VS_POL        = DEF_VS_POL,
  parameter int                  SPLASH_FRAMES = DEF_SPLASH_FRAMES,
  parameter int                  BLINK_FRAMES  = DEF_BLINK_FRAMES,
  parameter int                  FLASH_TOGGLES = DEF_FLASH_TOGGLES,
  parameter logic [STATUS_W-1:0] SPLASH_STATUS = DEF_SPLASH_STATUS
) (
  input  logic                vga_clk,
  input  logic                sys_rst_n,
  input  logic                vsync,
  input  logic                req_valid,
  input  logic [STATUS_W-1:0] req_status,
  input  logic [NUM_W-1:0]    req_num,
  input  logic                req_flash,
  output logic                req_ready,
  output logic [STATUS_W-1:0] status,
  output logic [NUM_W-1:0]    num,
  output logic                blank,
  output logic                frame_tick
);

  localparam logic [7:0] SPLASH_LAST = 8'(SPLASH_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] TOGGLES_N   = 8'(FLASH_TOGGLES);

  sched_state_e        state, state_nxt;
  logic [7:0]          fcnt, fcnt_nxt;
  logic [7:0]          tcnt, tcnt_nxt;
  logic                blank_nxt;
  logic [STATUS_W-1:0] status_nxt;
  logic [NUM_W-1:0]    num_nxt;
  logic                pend_valid, pend_valid_nxt;
  pend_t               pend, pend_nxt;
  logic                tick;
  logic                splash_done;
  logic                commit;

  vga_frame_edge #(.VS_POL(VS_POL)) u_frame_edge (
    .clk        (vga_clk),
    .rst_n      (sys_rst_n),
    .vsync      (vsync),
    .tick       (tick),
    .frame_tick (frame_tick)
  );

  assign req_ready   = ~pend_valid;
  assign splash_done = (state == ST_SPLASH) && (fcnt == SPLASH_LAST);
  assign commit      = tick && pend_valid && ((state != ST_SPLASH) || splash_done);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_SPLASH;
      fcnt       <= 8'd0;
      tcnt       <= 8'd0;
      blank      <= 1'b0;
      status     <= SPLASH_STATUS;
      num        <= '0;
      pend_valid <= 1'b0;
      pend       <= '0;
    end else begin
      state      <= state_nxt;
      fcnt       <= fcnt_nxt;
      tcnt       <= tcnt_nxt;
      blank      <= blank_nxt;
      status     <= status_nxt;
      num        <= num_nxt;
      pend_valid <= pend_valid_nxt;
      pend       <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    fcnt_nxt       = fcnt;
    tcnt_nxt       = tcnt;
    blank_nxt      = blank;
    status_nxt     = status;
    num_nxt        = num;
    pend_valid_nxt = pend_valid;
    pend_nxt       = pend;

    if (req_valid && !pend_valid) begin
      pend_valid_nxt = 1'b1;
      pend_nxt       = '{status: req_status, num: req_num, flash: req_flash};
    end

    unique case (state)
      ST_SPLASH: begin
        if (tick) begin
          if (splash_done) begin
            state_nxt = ST_RUN;
            fcnt_nxt  = 8'd0;
          end else begin
            fcnt_nxt = fcnt + 8'd1;
          end
        end
      end
      ST_RUN: blank_nxt = 1'b0;
      ST_FLASH: begin
        if (tick) begin
          if (fcnt == BLINK_LAST) begin
            blank_nxt = ~blank;
            fcnt_nxt  = 8'd0;
            tcnt_nxt  = tcnt + 8'd1;
            if (tcnt + 8'd1 == TOGGLES_N) begin
              state_nxt = ST_RUN;
              blank_nxt = 1'b0;
            end
          end else begin
            fcnt_nxt = fcnt + 8'd1;
          end
        end
      end
      default: state_nxt = ST_SPLASH;
    endcase

    // A commit overrides splash exit and blink toggling on the same tick
    if (commit) begin
      status_nxt     = pend.status;
      num_nxt        = pend.num;
      pend_valid_nxt = 1'b0;
      if (pend.flash) begin
        state_nxt = ST_FLASH;
        blank_nxt = 1'b1;
        fcnt_nxt  = 8'd0;
        tcnt_nxt  = 8'd1;
      end else begin
        state_nxt = ST_RUN;
        blank_nxt = 1'b0;
      end
    end
  end

endmodule
